// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32 core (lw, sw, R-type, I-type ALU, beq, jal).
// Drives PC/IR/regfile/memory enables and datapath mux selects; stalls on mem_ready.
module multicycle_controller #(
   parameter logic MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_e state_q, state_d;
   logic   mem_go;
   logic   opcode_legal;
   logic   pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;
   logic [2:0] funct_op;

   // With MEM_WAIT_EN=0 memory is assumed single-cycle and mem_ready is ignored.
   assign mem_go = mem_ready | ~MEM_WAIT_EN;

   assign opcode_legal = (opcode == OP_LW)  || (opcode == OP_SW) ||
                         (opcode == OP_R)   || (opcode == OP_I)  ||
                         (opcode == OP_JAL) || (opcode == OP_BEQ);

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = mem_go ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = mem_go ? S_FETCH : S_MEMWRITE;
         S_MEMWB:    state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      funct_op = ALU_ADD;
      case (funct3)
         3'b000:  funct_op = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_op = ALU_SLT;
         3'b110:  funct_op = ALU_OR;
         3'b111:  funct_op = ALU_AND;
         default: funct_op = ALU_ADD;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      case (opcode)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   always_comb begin
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      adr_src       = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_control   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
            ir_write_raw = mem_go;
            pc_write_raw = mem_go;
         end
         S_DECODE: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b01;
            illegal_raw = ~opcode_legal;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = funct_op;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = funct_op;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
         end
         S_JAL: begin
            alu_src_a    = 2'b01;
            alu_src_b    = 2'b10;
            pc_write_raw = 1'b1;
         end
         S_BEQ: begin
            alu_src_a    = 2'b10;
            alu_control  = ALU_SUB;
            pc_write_raw = zero;
         end
         default: ;
      endcase
   end

   // Reset aborts any instruction in flight, including a held MEMWRITE.
   assign pc_write  = pc_write_raw  & ~reset;
   assign mem_write = mem_write_raw & ~reset;
   assign ir_write  = ir_write_raw  & ~reset;
   assign reg_write = reg_write_raw & ~reset;
   assign illegal   = illegal_raw   & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios then randomized traffic,
// compared against a per-instruction phase-list reference model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   // Instruction kinds: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unsupported opcode.
   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;
   int   plan[$];
   int   forced_kind = -1;
   int   forced_f3 = -1;
   int   forced_f7 = -1;
   int   forced_op = -1;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   function automatic logic is_legal(input logic [6:0] op);
      return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
             op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011;
   endfunction

   task automatic start_instr();
      int kind;
      logic [6:0] op;
      kind = (forced_kind >= 0) ? forced_kind : int'($urandom_range(0, 6));
      case (kind)
         0: begin opcode = 7'b0000011; plan = '{0, 1, 2, 3, 4}; end
         1: begin opcode = 7'b0100011; plan = '{0, 1, 2, 5}; end
         2: begin opcode = 7'b0110011; plan = '{0, 1, 6, 7}; end
         3: begin opcode = 7'b0010011; plan = '{0, 1, 8, 7}; end
         4: begin opcode = 7'b1100011; plan = '{0, 1, 10}; end
         5: begin opcode = 7'b1101111; plan = '{0, 1, 9, 7}; end
         default: begin
            if (forced_op >= 0) op = 7'(forced_op);
            else begin
               op = 7'($urandom);
               while (is_legal(op)) op = 7'($urandom);
            end
            opcode = op;
            plan = '{0, 1};
         end
      endcase
      funct3   = (forced_f3 >= 0) ? 3'(forced_f3) : 3'($urandom);
      funct7b5 = (forced_f7 >= 0) ? 1'(forced_f7) : 1'($urandom);
      forced_kind = -1; forced_f3 = -1; forced_f7 = -1; forced_op = -1;
   endtask

   // One clock cycle: drive inputs, check outputs against the phase model, advance.
   task automatic step(input logic rdy, input logic zr, input logic rst);
      int ph;
      logic en;
      logic       e_pcw, e_adr, e_mw, e_irw, e_rw, e_ill;
      logic [1:0] e_rs, e_a, e_b, e_imm;
      logic [2:0] e_alu, fop;
      if (plan.size() == 0) start_instr();
      mem_ready = rdy; zero = zr; reset = rst;
      #1;
      ph = plan[0];
      en = !rst;
      e_pcw = 0; e_adr = 0; e_mw = 0; e_irw = 0; e_rw = 0; e_ill = 0;
      e_rs = 0; e_a = 0; e_b = 0; e_alu = 0;
      case (funct3)
         3'b000:  fop = (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
         3'b010:  fop = 3'b101;
         3'b110:  fop = 3'b011;
         3'b111:  fop = 3'b010;
         default: fop = 3'b000;
      endcase
      case (ph)
         0:  begin e_b = 2; e_rs = 2; e_irw = en && rdy; e_pcw = en && rdy; end
         1:  begin e_a = 1; e_b = 1; e_ill = en && !is_legal(opcode); end
         2:  begin e_a = 2; e_b = 1; end
         3:  begin e_adr = 1; end
         4:  begin e_rs = 1; e_rw = en; end
         5:  begin e_adr = 1; e_mw = en; end
         6:  begin e_a = 2; e_alu = fop; end
         7:  begin e_rw = en; end
         8:  begin e_a = 2; e_b = 1; e_alu = fop; end
         9:  begin e_a = 1; e_b = 2; e_pcw = en; end
         10: begin e_a = 2; e_alu = 3'b001; e_pcw = en && zr; end
         default: ;
      endcase
      case (opcode)
         7'b0100011: e_imm = 1;
         7'b1100011: e_imm = 2;
         7'b1101111: e_imm = 3;
         default:    e_imm = 0;
      endcase
      check("state",       8'(state),       8'(ph));
      check("pc_write",    8'(pc_write),    8'(e_pcw));
      check("adr_src",     8'(adr_src),     8'(e_adr));
      check("mem_write",   8'(mem_write),   8'(e_mw));
      check("ir_write",    8'(ir_write),    8'(e_irw));
      check("result_src",  8'(result_src),  8'(e_rs));
      check("alu_src_a",   8'(alu_src_a),   8'(e_a));
      check("alu_src_b",   8'(alu_src_b),   8'(e_b));
      check("imm_src",     8'(imm_src),     8'(e_imm));
      check("alu_control", 8'(alu_control), 8'(e_alu));
      check("reg_write",   8'(reg_write),   8'(e_rw));
      check("illegal",     8'(illegal),     8'(e_ill));
      @(posedge clk);
      #1;
      cycle++;
      if (rst) plan.delete();
      else if (!((ph == 0 || ph == 3 || ph == 5) && !rdy)) void'(plan.pop_front());
   endtask

   // Finish whatever instruction is in flight so the next one can be forced.
   task automatic drain();
      for (int i = 0; i < 20 && plan.size() != 0; i++) step(1'b1, 1'b0, 1'b0);
      check("drain_idle", 8'(plan.size()), 8'd0);
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
      opcode = '0; funct3 = '0; funct7b5 = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;

      // Reset held two cycles while in EXECR, then FETCH waits for mem_ready.
      forced_kind = 2;
      step(1, 0, 0); step(1, 0, 0);
      check("t1_in_execr", 8'(state), 8'd6);
      step(1, 0, 1); step(0, 0, 1);
      step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
      drain();

      // lw with mem always ready.
      forced_kind = 0;
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      check("t2_back_fetch", 8'(plan.size()), 8'd0);

      // sw with MEMWRITE held three cycles.
      forced_kind = 1;
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
      check("t3_sw_done", 8'(state), 8'd0);

      // R-type funct decode: sub, or, slt.
      forced_kind = 2; forced_f3 = 0; forced_f7 = 1;
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      forced_kind = 2; forced_f3 = 6; forced_f7 = 0;
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      forced_kind = 2; forced_f3 = 2; forced_f7 = 1;
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      forced_kind = 3; forced_f3 = 0; forced_f7 = 1;
      for (int i = 0; i < 4; i++) step(1, 0, 0);

      // beq taken then not taken.
      forced_kind = 4;
      step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
      forced_kind = 4;
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);

      // Unsupported opcode then jal.
      forced_kind = 6; forced_op = 7'h7f;
      step(1, 0, 0); step(1, 0, 0);
      forced_kind = 5;
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      check("t6_jal_done", 8'(state), 8'd0);

      // Randomized traffic with stalls, branch outcomes and occasional reset.
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 49) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
